// File: rtl/cpu_program_counter_pkg.sv
// -----------------------------------------------------------------------------
// cpu_program_counter_pkg
// Shared CPU definitions for the program counter and its return stack:
//   - default program-address width and reset vector
//   - pc_op encodings requested by the instruction decoder
//   - BOOT/RUN state encoding of the program counter FSM
//   - helper that folds unused pc_op codes onto NEXT
// -----------------------------------------------------------------------------
package cpu_program_counter_pkg;

  localparam int                PC_WIDTH_DEF     = 9;
  localparam logic [PC_WIDTH_DEF-1:0] RESET_VECTOR_DEF = 9'h1FF;
  localparam int                STACK_DEPTH      = 2;

  typedef enum logic [2:0] {
    PC_NEXT = 3'b000,
    PC_SKIP = 3'b001,
    PC_GOTO = 3'b010,
    PC_CALL = 3'b011,
    PC_RET  = 3'b100
  } pc_op_e;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } pc_state_e;

  // Codes 101..111 are not assigned to any operation and behave as NEXT.
  function automatic pc_op_e decode_pc_op(input logic [2:0] raw);
    case (raw)
      3'b001:  return PC_SKIP;
      3'b010:  return PC_GOTO;
      3'b011:  return PC_CALL;
      3'b100:  return PC_RET;
      default: return PC_NEXT;
    endcase
  endfunction

endpackage

// File: rtl/cpu_program_counter_return_stack.sv
// -----------------------------------------------------------------------------
// cpu_return_stack
// Two-entry hardware return stack. A push shifts stack0 into stack1 and stores
// the new address in stack0 (a third nested push silently drops the oldest
// entry). A pop exposes stack1 in stack0 and leaves stack1 in place, so the
// bottom level duplicates and an empty pop just returns stack0.
//
// Optional feature (macro CPU_STACK_ERR_EN): a saturating depth counter
// (0..2) drives sticky overflow/underflow flags, cleared only by reset.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset (clears both entries)
//   push_i       store push_data_i on top of the stack
//   pop_i        discard the top entry
//   push_data_i  address to push
//   top_o        current top of stack (stack0)
//   stk_ovf_o    sticky: push while full          (CPU_STACK_ERR_EN only)
//   stk_unf_o    sticky: pop while empty          (CPU_STACK_ERR_EN only)
// -----------------------------------------------------------------------------
module cpu_return_stack
  import cpu_program_counter_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [PC_WIDTH-1:0] push_data_i,
  output logic [PC_WIDTH-1:0] top_o
`ifdef CPU_STACK_ERR_EN
  ,
  output logic                stk_ovf_o,
  output logic                stk_unf_o
`endif
);

  logic [PC_WIDTH-1:0] stack0_q;
  logic [PC_WIDTH-1:0] stack1_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stack0_q <= '0;
      stack1_q <= '0;
    end else if (push_i) begin
      stack1_q <= stack0_q;
      stack0_q <= push_data_i;
    end else if (pop_i) begin
      stack0_q <= stack1_q;
    end
  end

  assign top_o = stack0_q;

`ifdef CPU_STACK_ERR_EN
  logic [1:0] depth_q;
  logic       ovf_q;
  logic       unf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      depth_q <= 2'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (push_i) begin
      if (depth_q == 2'(STACK_DEPTH)) ovf_q   <= 1'b1;
      else                            depth_q <= depth_q + 2'd1;
    end else if (pop_i) begin
      if (depth_q == 2'd0) unf_q   <= 1'b1;
      else                 depth_q <= depth_q - 2'd1;
    end
  end

  assign stk_ovf_o = ovf_q;
  assign stk_unf_o = unf_q;
`endif

endmodule

// File: rtl/cpu_program_counter.sv
// -----------------------------------------------------------------------------
// cpu_program_counter
// Program counter with a two-level return stack for a two-stage
// (fetch / execute) CPU. pc_out always addresses the instruction following the
// one held in the instruction register; any change of flow therefore makes
// the already-fetched word stale, which is signalled by the registered flush
// output for one unstalled cycle.
//
// Optional feature: define CPU_STACK_ERR_EN to add the stk_ovf / stk_unf
// sticky error outputs of the return stack.
//
// Ports:
//   clk               clock, rising edge
//   rst               asynchronous active-low reset
//   stall             hold all state, suppress load_instruction
//   pc_op[2:0]        NEXT / SKIP / GOTO / CALL / RETURN (101-111 = NEXT)
//   target            GOTO target; CALL uses the low 8 bits only
//   pcl_write         decoder writes PCL this cycle (wins over pc_op)
//   pcl_data[7:0]     new PCL value
//   pc_out            registered program-memory fetch address
//   load_instruction  instruction register captures the program word
//   flush             instruction register holds a discarded prefetch
//   stk_ovf, stk_unf  sticky stack errors (CPU_STACK_ERR_EN only)
// -----------------------------------------------------------------------------
module cpu_program_counter
  import cpu_program_counter_pkg::*;
#(
  parameter int                  PC_WIDTH     = PC_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(RESET_VECTOR_DEF)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic [2:0]          pc_op,
  input  logic [PC_WIDTH-1:0] target,
  input  logic                pcl_write,
  input  logic [7:0]          pcl_data,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                load_instruction,
  output logic                flush
`ifdef CPU_STACK_ERR_EN
  ,
  output logic                stk_ovf,
  output logic                stk_unf
`endif
);

  pc_state_e           state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                flush_q, flush_d;
  logic                push, pop;
  logic [PC_WIDTH-1:0] stk_top;
  logic [PC_WIDTH-1:0] pc_inc;
  pc_op_e              op;

  assign pc_inc = pc_q + PC_WIDTH'(1);
  assign op     = decode_pc_op(pc_op);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush_d = flush_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (!stall) begin
      if (state_q == ST_BOOT) begin
        // The reset vector was fetched during BOOT; just move on to the next word.
        state_d = ST_RUN;
        pc_d    = pc_inc;
        flush_d = 1'b0;
      end else if (flush_q) begin
        // The instruction register holds a dead prefetch: ignore its decode.
        pc_d    = pc_inc;
        flush_d = 1'b0;
      end else if (pcl_write) begin
        pc_d    = PC_WIDTH'(pcl_data);
        flush_d = 1'b1;
      end else begin
        case (op)
          PC_SKIP: begin
            pc_d    = pc_inc;
            flush_d = 1'b1;
          end
          PC_GOTO: begin
            pc_d    = target;
            flush_d = 1'b1;
          end
          PC_CALL: begin
            // pc_out already points past the CALL, so it is the return address.
            pc_d    = PC_WIDTH'(target[7:0]);
            flush_d = 1'b1;
            push    = 1'b1;
          end
          PC_RET: begin
            pc_d    = stk_top;
            flush_d = 1'b1;
            pop     = 1'b1;
          end
          default: begin
            pc_d    = pc_inc;
            flush_d = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
    end
  end

  cpu_return_stack #(
    .PC_WIDTH(PC_WIDTH)
  ) u_stack (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (pc_q),
    .top_o       (stk_top)
`ifdef CPU_STACK_ERR_EN
    ,
    .stk_ovf_o   (stk_ovf),
    .stk_unf_o   (stk_unf)
`endif
  );

  assign pc_out           = pc_q;
  assign flush            = flush_q;
  assign load_instruction = (state_q == ST_RUN) && !stall;

endmodule

// File: tb/tb_cpu_program_counter.sv
module tb_cpu_program_counter;
  import cpu_program_counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stall = 1'b0;
  logic [2:0] pc_op = 3'b000;
  logic [8:0] target = '0;
  logic       pcl_write = 1'b0;
  logic [7:0] pcl_data = '0;
  logic [8:0] pc_out;
  logic       load_instruction;
  logic       flush;
`ifdef CPU_STACK_ERR_EN
  logic       stk_ovf;
  logic       stk_unf;
`endif

  cpu_program_counter dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .pc_op            (pc_op),
    .target           (target),
    .pcl_write        (pcl_write),
    .pcl_data         (pcl_data),
    .pc_out           (pc_out),
    .load_instruction (load_instruction),
    .flush            (flush)
`ifdef CPU_STACK_ERR_EN
    ,
    .stk_ovf          (stk_ovf),
    .stk_unf          (stk_unf)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [8:0] pc;
    logic       fl;
    logic       ovf;
    logic       unf;
    string      tag;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [8:0] m_pc, m_s0, m_s1;
  logic       m_fl, m_boot, m_ovf, m_unf;
  int         m_depth;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 9'h1FF; m_s0 = '0; m_s1 = '0;
    m_fl = 1'b0; m_boot = 1'b1; m_ovf = 1'b0; m_unf = 1'b0; m_depth = 0;
  endtask

  task automatic model_step(input logic [2:0] op, input logic [8:0] tg,
                            input logic pw, input logic [7:0] pd, input logic st);
    if (st) return;
    if (m_boot) begin
      m_boot = 1'b0; m_pc = m_pc + 9'd1; m_fl = 1'b0;
    end else if (m_fl) begin
      m_pc = m_pc + 9'd1; m_fl = 1'b0;
    end else if (pw) begin
      m_pc = {1'b0, pd}; m_fl = 1'b1;
    end else begin
      case (op)
        3'b001: begin m_pc = m_pc + 9'd1; m_fl = 1'b1; end
        3'b010: begin m_pc = tg; m_fl = 1'b1; end
        3'b011: begin
          m_s1 = m_s0; m_s0 = m_pc; m_pc = {1'b0, tg[7:0]}; m_fl = 1'b1;
          if (m_depth == 2) m_ovf = 1'b1; else m_depth++;
        end
        3'b100: begin
          m_pc = m_s0; m_s0 = m_s1; m_fl = 1'b1;
          if (m_depth == 0) m_unf = 1'b1; else m_depth--;
        end
        default: begin m_pc = m_pc + 9'd1; m_fl = 1'b0; end
      endcase
    end
  endtask

  // Drive one cycle of stimulus mid-cycle, check the combinational load
  // output, queue the expected post-edge state and compare after the edge.
  task automatic step(input logic [2:0] op, input logic [8:0] tg, input logic pw,
                      input logic [7:0] pd, input logic st, input string tag);
    exp_t e;
    pc_op = op; target = tg; pcl_write = pw; pcl_data = pd; stall = st;
    #1;
    chk({tag, ".load"}, {31'd0, load_instruction}, {31'd0, (!st && !m_boot)});
    model_step(op, tg, pw, pd, st);
    e.pc = m_pc; e.fl = m_fl; e.ovf = m_ovf; e.unf = m_unf; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".pc"}, {23'd0, pc_out}, {23'd0, e.pc});
    chk({e.tag, ".flush"}, {31'd0, flush}, {31'd0, e.fl});
`ifdef CPU_STACK_ERR_EN
    chk({e.tag, ".ovf"}, {31'd0, stk_ovf}, {31'd0, e.ovf});
    chk({e.tag, ".unf"}, {31'd0, stk_unf}, {31'd0, e.unf});
`endif
    pc_op = 3'b000; pcl_write = 1'b0; stall = 1'b0;
  endtask

  task automatic nxt(input string tag);
    step(3'b000, 9'h000, 1'b0, 8'h00, 1'b0, tag);
  endtask

  // Assert reset between edges, confirm the asynchronous clear, release on a
  // falling edge so the next step starts in BOOT.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    chk({tag, ".rst_pc"}, {23'd0, pc_out}, 32'h1FF);
    chk({tag, ".rst_flush"}, {31'd0, flush}, 32'd0);
    chk({tag, ".rst_load"}, {31'd0, load_instruction}, 32'd0);
`ifdef CPU_STACK_ERR_EN
    chk({tag, ".rst_ovf"}, {31'd0, stk_ovf}, 32'd0);
    chk({tag, ".rst_unf"}, {31'd0, stk_unf}, 32'd0);
`endif
    @(posedge clk);
    #1;
    chk({tag, ".held_pc"}, {23'd0, pc_out}, 32'h1FF);
    @(negedge clk);
    rst = 1'b1;
    pc_op = 3'b000;
    model_reset();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #2;

    // Reset release and sequential fetch
    do_reset("r0");
    chk("boot_pc", {23'd0, pc_out}, 32'h1FF);
    nxt("boot");
    chk("seq0", {23'd0, pc_out}, 32'h000);
    nxt("seq1");
    nxt("seq2");
    chk("seq2c", {23'd0, pc_out}, 32'h002);

    // GOTO, with CALL ignored during the flush cycle
    step(3'b000, 9'h000, 1'b1, 8'h0F, 1'b0, "pcl0f");
    nxt("to010");
    step(PC_GOTO, 9'h0A5, 1'b0, 8'h00, 1'b0, "goto");
    chk("goto_c", {23'd0, pc_out}, 32'h0A5);
    chk("goto_f", {31'd0, flush}, 32'd1);
    step(PC_CALL, 9'h033, 1'b0, 8'h00, 1'b0, "call_in_flush");
    chk("cif_c", {23'd0, pc_out}, 32'h0A6);
    chk("cif_f", {31'd0, flush}, 32'd0);

    // CALL / RETURN
    step(PC_GOTO, 9'h01F, 1'b0, 8'h00, 1'b0, "to01f");
    nxt("to020");
    step(PC_CALL, 9'h1C5, 1'b0, 8'h00, 1'b0, "call");
    chk("call_c", {23'd0, pc_out}, 32'h0C5);
    nxt("call_fl");
    nxt("sub1");
    step(PC_RET, 9'h000, 1'b0, 8'h00, 1'b0, "ret");
    chk("ret_c", {23'd0, pc_out}, 32'h020);
    chk("ret_f", {31'd0, flush}, 32'd1);
    nxt("ret_fl");

    // Three nested CALLs from 030, 040, 050 then three RETURNs
    do_reset("r1");
    nxt("boot1");
    step(PC_GOTO, 9'h02F, 1'b0, 8'h00, 1'b0, "n_to02f");
    nxt("n_to030");
    step(PC_CALL, 9'h03F, 1'b0, 8'h00, 1'b0, "n_call1");
    nxt("n_to040");
    step(PC_CALL, 9'h04F, 1'b0, 8'h00, 1'b0, "n_call2");
    nxt("n_to050");
    step(PC_CALL, 9'h0AA, 1'b0, 8'h00, 1'b0, "n_call3");
`ifdef CPU_STACK_ERR_EN
    chk("n_ovf_c", {31'd0, stk_ovf}, 32'd1);
`endif
    nxt("n_fl3");
    step(PC_RET, 9'h000, 1'b0, 8'h00, 1'b0, "n_ret1");
    chk("n_ret1_c", {23'd0, pc_out}, 32'h050);
    nxt("n_fl4");
    step(PC_RET, 9'h000, 1'b0, 8'h00, 1'b0, "n_ret2");
    chk("n_ret2_c", {23'd0, pc_out}, 32'h040);
    nxt("n_fl5");
    step(PC_RET, 9'h000, 1'b0, 8'h00, 1'b0, "n_ret3");
    chk("n_ret3_c", {23'd0, pc_out}, 32'h040);
`ifdef CPU_STACK_ERR_EN
    chk("n_unf_c", {31'd0, stk_unf}, 32'd1);
`endif
    nxt("n_fl6");

    // SKIP then a 3-cycle stall; flush survives the stall
    step(PC_SKIP, 9'h000, 1'b0, 8'h00, 1'b0, "skip");
    chk("skip_f", {31'd0, flush}, 32'd1);
    step(PC_GOTO, 9'h123, 1'b0, 8'h00, 1'b1, "stall1");
    step(PC_CALL, 9'h055, 1'b1, 8'h44, 1'b1, "stall2");
    step(PC_RET, 9'h000, 1'b0, 8'h00, 1'b1, "stall3");
    chk("stall_f", {31'd0, flush}, 32'd1);
    chk("stall_pc", {23'd0, pc_out}, 32'h042);
    nxt("skip_rel");
    chk("skip_rel_f", {31'd0, flush}, 32'd0);
    nxt("after_skip");

    // pcl_write wins over GOTO in the same cycle
    step(PC_GOTO, 9'h100, 1'b1, 8'h7F, 1'b0, "pcl_vs_goto");
    chk("pcl_c", {23'd0, pc_out}, 32'h07F);
    nxt("pcl_fl");

    // Wrap-around and unused op codes
    step(PC_GOTO, 9'h1FE, 1'b0, 8'h00, 1'b0, "to1fe");
    nxt("to1ff");
    nxt("wrap");
    chk("wrap_c", {23'd0, pc_out}, 32'h000);
    step(3'b101, 9'h0F0, 1'b0, 8'h00, 1'b0, "op5");
    step(3'b110, 9'h0F0, 1'b0, 8'h00, 1'b0, "op6");
    step(3'b111, 9'h0F0, 1'b0, 8'h00, 1'b0, "op7");
    chk("op7_c", {23'd0, pc_out}, 32'h003);

    // Reset pulsed in the middle of a CALL: stack comes back empty
    step(PC_CALL, 9'h066, 1'b0, 8'h00, 1'b0, "pre_call");
    nxt("pre_fl");
    pc_op = PC_CALL; target = 9'h033;
    #2;
    do_reset("r2");
    chk("r2_pc", {23'd0, pc_out}, 32'h1FF);
    step(3'b000, 9'h000, 1'b0, 8'h00, 1'b1, "boot_stall");
    chk("boot_stall_c", {23'd0, pc_out}, 32'h1FF);
    nxt("boot2");
    step(PC_RET, 9'h000, 1'b0, 8'h00, 1'b0, "ret_empty");
    chk("ret_empty_c", {23'd0, pc_out}, 32'h000);
    nxt("ret_empty_fl");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_program_counter.md
CPU_PROGRAM_COUNTER -- requirements
Module: cpu_program_counter

Interface
REQ-001 Parameter PC_WIDTH, default 9, program-address width (512 words).
REQ-002 Parameter RESET_VECTOR, default 9'h1FF, address fetched first after reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; low clears state immediately regardless of clk.
REQ-005 stall  input  1  high: hold all state; load_instruction low.
REQ-006 pc_op  input  3  decoder request: 000 NEXT, 001 SKIP, 010 GOTO, 011 CALL, 100 RETURN; 101-111 treated as NEXT.
REQ-007 target  input  9  GOTO target k[8:0]; CALL uses k[7:0] with bit 8 forced to 0.
REQ-008 pcl_write  input  1  decoder writes PCL this cycle.
REQ-009 pcl_data  input  8  new PCL value.
REQ-010 pc_out  output  PC_WIDTH  program-memory fetch address (registered).
REQ-011 load_instruction  output  1  instruction register captures program word at the next edge.
REQ-012 flush  output  1  registered; current instruction-register content is a discarded prefetch, to be executed as NOP.

Function
REQ-013 States: BOOT (first cycle after reset release; load_instruction=0, pc_out=RESET_VECTOR) and RUN; BOOT->RUN unconditionally on the first edge with stall=0.
REQ-014 In RUN, load_instruction = !stall, combinationally.
REQ-015 pc_out always addresses the instruction after the one in the instruction register; CALL therefore pushes pc_out unmodified.
REQ-016 NEXT: pc_out <= pc_out+1, modulo 2^PC_WIDTH (9'h1FF+1 -> 9'h000); flush <= 0.
REQ-017 SKIP: pc_out <= pc_out+1; flush <= 1 for exactly one unstalled cycle (two-cycle skip).
REQ-018 GOTO: pc_out <= target; flush <= 1.
REQ-019 CALL: stack1 <= stack0; stack0 <= pc_out; pc_out <= {1'b0,target[7:0]}; flush <= 1.
REQ-020 RETURN: pc_out <= stack0; stack0 <= stack1; stack1 unchanged (bottom level duplicates); flush <= 1.
REQ-021 pcl_write (flush=0): pc_out <= {1'b0,pcl_data}; flush <= 1; overrides pc_op in the same cycle, stack untouched.
REQ-022 While flush=1 the block ignores pc_op and pcl_write, performs NEXT, and clears flush.
REQ-023 Stack depth 2; a third nested CALL overwrites stack1 silently; RETURN with empty stack returns stack0 contents (no error).
REQ-024 stall=1: pc_out, stack, flush, and state hold; pc_op/pcl_write ignored; a pending flush survives the stall.

Reset
REQ-025 rst low: pc_out=RESET_VECTOR, stack0=stack1=0, flush=0, load_instruction=0, state=BOOT, error flags (if compiled in) 0.
REQ-026 Reset asserted mid-branch discards the branch; no partial stack update is visible after release.

Configuration
REQ-027 Macro CPU_STACK_ERR_EN defined: adds outputs stk_ovf and stk_unf (1 bit each, sticky until reset), driven from a 2-bit depth counter (0..2, saturating); CALL at depth 2 sets stk_ovf; RETURN at depth 0 sets stk_unf.
REQ-028 Macro undefined: ports and depth counter absent; stack behaviour identical to REQ-019/020/023.

Structure
REQ-029 Shared CPU package holds PC_WIDTH, RESET_VECTOR default, and pc_op encodings (PC_NEXT, PC_SKIP, PC_GOTO, PC_CALL, PC_RET).
REQ-030 One sub-module cpu_return_stack (2-entry push/pop, optional error counter); next-PC mux and BOOT/RUN FSM stay in the top.

Verification
REQ-031 Reset release, stall=0, NEXT x3 -> pc_out 1FF, 000, 001, 002; load_instruction 0 in BOOT, then 1.
REQ-032 At pc_out=010 GOTO target=0A5 -> pc_out=0A5, flush=1 one cycle; pc_op=CALL during flush is ignored, pc_out=0A6.
REQ-033 At pc_out=020 CALL k=1C5 -> pc_out=0C5, stack0=020; later RETURN -> pc_out=020, flush=1.
REQ-034 Three nested CALLs from 030, 040, 050 then three RETURNs -> pc_out 050, 040, 040; with CPU_STACK_ERR_EN stk_ovf=1 after third CALL, stk_unf=1 after third RETURN.
REQ-035 SKIP asserted then stall=1 for 3 cycles -> pc_out and flush=1 held, load_instruction=0; on release flush clears after one cycle.
REQ-036 pcl_write with pcl_data=7F and pc_op=GOTO target=100 same cycle -> pc_out=07F; rst pulsed low mid-CALL -> pc_out=1FF, stack zero.
